// File: rtl/telemetry_rx_if.sv
// Byte stream from UART_rcv into the telemetry decoder, plus decoded values,
// frame/error statistics and the decoder's state for observation.
interface telemetry_rx_if;
   // rx_rdy/clr_rdy: a byte moves on every rising edge where rx_rdy is high.
   // clr_rdy mirrors rx_rdy combinationally because the decoder never stalls.
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rdy;
   logic [11:0] batt;
   logic [11:0] curr;
   logic [11:0] torque;
   logic        vld;
   logic        frm_err;
   logic [15:0] frm_cnt;
   logic [7:0]  err_cnt;
   logic [1:0]  state;

   modport master (
      output rx_rdy, rx_data,
      input  clr_rdy, batt, curr, torque, vld, frm_err, frm_cnt, err_cnt, state
   );

   modport slave (
      input  rx_rdy, rx_data,
      output clr_rdy, batt, curr, torque, vld, frm_err, frm_cnt, err_cnt, state
   );
endinterface

// File: rtl/telemetry_rx.sv
// Decodes 8-byte telemetry frames (AA 55 + three 12-bit values) from UART_rcv,
// commits values with a vld strobe and keeps good/bad frame counters.
module telemetry_rx #(
   parameter logic [19:0] TIMEOUT = 20'd200000
) (
   input  logic           clk,
   input  logic           rst,
   telemetry_rx_if.slave  bus
);

   localparam logic [1:0] SYNC1   = 2'd0;
   localparam logic [1:0] SYNC2   = 2'd1;
   localparam logic [1:0] PAYLOAD = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [19:0] gap_q, gap_d;
   logic [11:0] sh_batt_q, sh_batt_d;
   logic [11:0] sh_curr_q, sh_curr_d;
   logic [3:0]  sh_torq_q, sh_torq_d;
   logic [11:0] batt_q, batt_d;
   logic [11:0] curr_q, curr_d;
   logic [11:0] torque_q, torque_d;
   logic        vld_q, vld_d;
   logic        frm_err_q, frm_err_d;
   logic [15:0] frm_cnt_q, frm_cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic [19:0] gap_inc;
   logic        take;

   assign bus.clr_rdy = bus.rx_rdy;
   assign take        = bus.rx_rdy;
   assign gap_inc     = gap_q + 20'd1;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      sh_batt_d = sh_batt_q;
      sh_curr_d = sh_curr_q;
      sh_torq_d = sh_torq_q;
      batt_d    = batt_q;
      curr_d    = curr_q;
      torque_d  = torque_q;
      vld_d     = 1'b0;
      frm_err_d = 1'b0;
      frm_cnt_d = frm_cnt_q;
      err_cnt_d = err_cnt_q;

      if (take || state_q == SYNC1) gap_d = '0;
      else                          gap_d = gap_inc;

      case (state_q)
         SYNC1: begin
            if (take && bus.rx_data == 8'hAA) state_d = SYNC2;
         end
         SYNC2: begin
            if (take) begin
               if (bus.rx_data == 8'h55) begin
                  state_d = PAYLOAD;
                  idx_d   = 3'd0;
               end else if (bus.rx_data != 8'hAA) begin
                  state_d   = SYNC1;
                  frm_err_d = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            if (take) begin
               // Even positions carry a value's high nibble; the top nibble must be zero.
               if (!idx_q[0] && bus.rx_data[7:4] != 4'h0) begin
                  state_d   = SYNC1;
                  frm_err_d = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
                  case (idx_q)
                     3'd0: sh_batt_d[11:8] = bus.rx_data[3:0];
                     3'd1: sh_batt_d[7:0]  = bus.rx_data;
                     3'd2: sh_curr_d[11:8] = bus.rx_data[3:0];
                     3'd3: sh_curr_d[7:0]  = bus.rx_data;
                     3'd4: sh_torq_d       = bus.rx_data[3:0];
                     default: begin
                        batt_d    = sh_batt_q;
                        curr_d    = sh_curr_q;
                        torque_d  = {sh_torq_q, bus.rx_data};
                        vld_d     = 1'b1;
                        frm_cnt_d = frm_cnt_q + 16'd1;
                        state_d   = SYNC1;
                        idx_d     = 3'd0;
                     end
                  endcase
               end
            end
         end
         default: state_d = SYNC1;
      endcase

      // A byte on the same edge keeps the frame alive, so timeout only fires on idle edges.
      if (!take && state_q != SYNC1 && gap_inc == TIMEOUT) begin
         state_d   = SYNC1;
         frm_err_d = 1'b1;
         gap_d     = '0;
      end

      if (frm_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SYNC1;
         idx_q     <= '0;
         gap_q     <= '0;
         sh_batt_q <= '0;
         sh_curr_q <= '0;
         sh_torq_q <= '0;
         batt_q    <= '0;
         curr_q    <= '0;
         torque_q  <= '0;
         vld_q     <= 1'b0;
         frm_err_q <= 1'b0;
         frm_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         sh_batt_q <= sh_batt_d;
         sh_curr_q <= sh_curr_d;
         sh_torq_q <= sh_torq_d;
         batt_q    <= batt_d;
         curr_q    <= curr_d;
         torque_q  <= torque_d;
         vld_q     <= vld_d;
         frm_err_q <= frm_err_d;
         frm_cnt_q <= frm_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.batt    = batt_q;
   assign bus.curr    = curr_q;
   assign bus.torque  = torque_q;
   assign bus.vld     = vld_q;
   assign bus.frm_err = frm_err_q;
   assign bus.frm_cnt = frm_cnt_q;
   assign bus.err_cnt = err_cnt_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Drives directed and random byte streams into telemetry_rx and compares every
// cycle against a frame-level reference model built on a byte queue.
module tb_telemetry_rx;

   localparam logic [19:0] TMO = 20'd100;

   logic clk = 1'b0;
   logic rst = 1'b1;

   telemetry_rx_if tif ();

   telemetry_rx #(.TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: bytes of the frame being assembled are held in a queue.
   logic [7:0]  mbuf[$];
   int          m_idle = 0;
   logic [11:0] m_batt = '0, m_curr = '0, m_torq = '0;
   logic        m_vld = 1'b0, m_err = 1'b0;
   logic [15:0] m_frm = '0;
   logic [7:0]  m_errc = '0;
   logic [7:0]  mb;
   logic [1:0]  m_state;

   task automatic m_fail();
      mbuf.delete();
      m_idle = 0;
      m_err  = 1'b1;
      if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mbuf.delete();
         m_idle = 0;
         m_batt = '0; m_curr = '0; m_torq = '0;
         m_vld = 1'b0; m_err = 1'b0;
         m_frm = '0; m_errc = '0;
      end else begin
         m_vld = 1'b0;
         m_err = 1'b0;
         if (tif.rx_rdy) begin
            m_idle = 0;
            mb = tif.rx_data;
            if (mbuf.size() == 0) begin
               if (mb == 8'hAA) mbuf.push_back(mb);
            end else if (mbuf.size() == 1) begin
               if (mb == 8'h55) mbuf.push_back(mb);
               else if (mb != 8'hAA) m_fail();
            end else if ((mbuf.size() % 2 == 0) && mb[7:4] != 4'h0) begin
               m_fail();
            end else begin
               mbuf.push_back(mb);
               if (mbuf.size() == 8) begin
                  m_batt = {mbuf[2][3:0], mbuf[3]};
                  m_curr = {mbuf[4][3:0], mbuf[5]};
                  m_torq = {mbuf[6][3:0], mbuf[7]};
                  m_vld  = 1'b1;
                  m_frm  = m_frm + 16'd1;
                  mbuf.delete();
               end
            end
         end else if (mbuf.size() != 0) begin
            m_idle++;
            if (m_idle == int'(TMO)) m_fail();
         end
      end
   end

   always_comb begin
      m_state = 2'd2;
      if (mbuf.size() == 0)      m_state = 2'd0;
      else if (mbuf.size() == 1) m_state = 2'd1;
   end

   always @(negedge clk) begin
      check("clr_rdy", tif.clr_rdy, tif.rx_rdy);
      check("vld", tif.vld, m_vld);
      check("frm_err", tif.frm_err, m_err);
      check("batt", tif.batt, m_batt);
      check("curr", tif.curr, m_curr);
      check("torque", tif.torque, m_torq);
      check("frm_cnt", tif.frm_cnt, m_frm);
      check("err_cnt", tif.err_cnt, m_errc);
      check("state", tif.state, m_state);
   end

   // Drivers: all stay aligned to 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      tif.rx_rdy  = 1'b1;
      tif.rx_data = b;
      @(posedge clk);
      #1;
      tif.rx_rdy  = 1'b0;
      tif.rx_data = 8'($urandom);
      idle(gap);
   endtask

   task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t,
                             input int maxgap);
      send_byte(8'hAA, $urandom_range(maxgap, 0));
      send_byte(8'h55, $urandom_range(maxgap, 0));
      send_byte({4'h0, b[11:8]}, $urandom_range(maxgap, 0));
      send_byte(b[7:0], $urandom_range(maxgap, 0));
      send_byte({4'h0, c[11:8]}, $urandom_range(maxgap, 0));
      send_byte(c[7:0], $urandom_range(maxgap, 0));
      send_byte({4'h0, t[11:8]}, $urandom_range(maxgap, 0));
      send_byte(t[7:0], $urandom_range(maxgap, 0));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst = 1'b0;
   endtask

   logic [7:0] garbage_tbl[4] = '{8'h13, 8'hAA, 8'hAA, 8'h55};
   logic [7:0] frm_bytes[8];
   int         kind;
   int         cut;

   initial begin
      tif.rx_rdy  = 1'b0;
      tif.rx_data = 8'h00;
      #1;
      do_reset(3);

      // Single frame.
      send_frame(12'hFFF, 12'h123, 12'h700, 0);
      check("t1_batt", tif.batt, 12'hFFF);
      check("t1_curr", tif.curr, 12'h123);
      check("t1_torque", tif.torque, 12'h700);
      check("t1_frm_cnt", tif.frm_cnt, 16'd1);
      check("t1_err_cnt", tif.err_cnt, 8'd0);

      // Leading garbage and re-sync on a repeated AA.
      for (int i = 0; i < 4; i++) send_byte(garbage_tbl[i], 1);
      send_byte(8'h00, 1); send_byte(8'h10, 1);
      send_byte(8'h00, 1); send_byte(8'h20, 1);
      send_byte(8'h00, 1); send_byte(8'h30, 1);
      check("t2_batt", tif.batt, 12'h010);
      check("t2_curr", tif.curr, 12'h020);
      check("t2_torque", tif.torque, 12'h030);
      check("t2_err_cnt", tif.err_cnt, 8'd0);

      // Bad high nibble.
      send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h1F, 1); send_byte(8'hFF, 1);
      check("t3_err_cnt", tif.err_cnt, 8'd1);
      check("t3_batt", tif.batt, 12'h010);
      send_frame(12'hABC, 12'h456, 12'h789, 1);
      check("t3_next_batt", tif.batt, 12'hABC);
      check("t3_next_torque", tif.torque, 12'h789);

      // Inter-byte timeout.
      send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h05, 0);
      idle(101);
      check("t4_err_cnt", tif.err_cnt, 8'd2);
      check("t4_state", tif.state, 2'd0);
      send_frame(12'h321, 12'h654, 12'h987, 2);
      check("t4_next_curr", tif.curr, 12'h654);

      // Reset mid-frame.
      send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h01, 0); send_byte(8'h23, 0);
      do_reset(2);
      check("t5_batt", tif.batt, 12'h000);
      check("t5_frm_cnt", tif.frm_cnt, 16'd0);
      check("t5_err_cnt", tif.err_cnt, 8'd0);
      send_frame(12'h111, 12'h222, 12'h333, 1);
      check("t5_next_frm_cnt", tif.frm_cnt, 16'd1);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(19, 0);
         frm_bytes[0] = 8'hAA;
         frm_bytes[1] = 8'h55;
         for (int k = 2; k < 8; k++)
            frm_bytes[k] = (k % 2 == 0) ? {4'h0, 4'($urandom)} : 8'($urandom);
         if (kind < 12) begin
            for (int k = 0; k < 8; k++) send_byte(frm_bytes[k], $urandom_range(2, 0));
         end else if (kind < 14) begin
            repeat ($urandom_range(6, 1)) send_byte(8'($urandom), $urandom_range(2, 0));
         end else if (kind < 17) begin
            frm_bytes[$urandom_range(7, 1)] = 8'($urandom);
            for (int k = 0; k < 8; k++) send_byte(frm_bytes[k], $urandom_range(2, 0));
         end else if (kind < 19) begin
            cut = $urandom_range(7, 1);
            for (int k = 0; k < cut; k++) send_byte(frm_bytes[k], 0);
            idle(int'(TMO) + $urandom_range(5, 0) - 2);
         end else begin
            cut = $urandom_range(7, 1);
            for (int k = 0; k < cut; k++) send_byte(frm_bytes[k], 0);
            do_reset($urandom_range(3, 1));
         end
      end

      // Error counter saturation.
      do_reset(2);
      for (int n = 0; n < 260; n++) begin
         send_byte(8'hAA, 0);
         send_byte(8'h00, 0);
      end
      check("sat_err_cnt", tif.err_cnt, 8'hFF);
      send_frame(12'h0F0, 12'hF0F, 12'h5A5, 0);
      check("sat_frm_cnt", tif.frm_cnt, 16'd1);
      check("sat_err_hold", tif.err_cnt, 8'hFF);

      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
